// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared states, sizing constants and byte-lane order for the loader
package instr_mem_loader_pkg;

  localparam int IMEM_DEPTH_WORDS = 128;
  localparam int IMEM_ADDR_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_FIN
  } loader_state_e;

  // Big-endian lanes: earlier bytes occupy higher lanes, so the first byte lands in [31:24].
  function automatic logic [31:0] lane_append(input logic [23:0] upper, input logic [7:0] b);
    return {upper, b};
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// rtl/instr_mem_loader_byte_assembler.sv - 8-to-32 shift register with byte counter and word_valid pulse
module instr_mem_loader_byte_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word       = lane_append(shift_q, byte_in);
  assign word_valid = byte_accept && !clear && (cnt_q == 2'd3);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_accept) begin
      shift_d = (cnt_q == 2'd3) ? 24'h0 : word[23:0];
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - serial byte loader into instruction memory with CPU stall
// Optional trailing XOR checksum word enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int ADDR_W      = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              error
);

  loader_state_e     state_q, state_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [7:0]        word_total_q, word_total_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              asm_word_valid;
  logic              byte_accept;
`ifdef LOADER_CHECKSUM_EN
  logic              ck_phase_q, ck_phase_d;
  logic [31:0]       csum_q, csum_d;
`endif

  assign byte_ready  = (state_q == ST_RECV);
  assign byte_accept = byte_valid && byte_ready;

  instr_mem_loader_byte_assembler u_byte_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (asm_clear),
    .byte_in     (byte_in),
    .byte_accept (byte_accept),
    .word        (asm_word),
    .word_valid  (asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    word_total_d = word_total_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    error_d      = error_q;
    asm_clear    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    ck_phase_d   = ck_phase_q;
    csum_d       = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d      = 1'b0;
          word_total_d = word_count;
          word_cnt_d   = '0;
          asm_clear    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          ck_phase_d   = (word_count == 8'd0);
          csum_d       = '0;
`endif
          if (32'(word_count) > DEPTH_WORDS) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else if (word_count == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_RECV;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (asm_word_valid) begin
`ifdef LOADER_CHECKSUM_EN
          if (ck_phase_q) begin
            error_d = (asm_word != csum_q);
            state_d = ST_FIN;
          end else begin
            csum_d    = csum_q ^ asm_word;
            wr_en_d   = 1'b1;
            wr_addr_d = word_cnt_q[ADDR_W-1:0];
            wr_data_d = asm_word;
            state_d   = ST_WRITE;
          end
`else
          wr_en_d   = 1'b1;
          wr_addr_d = word_cnt_q[ADDR_W-1:0];
          wr_data_d = asm_word;
          state_d   = ST_WRITE;
`endif
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 8'd1;
        if (word_cnt_d == word_total_q) begin
`ifdef LOADER_CHECKSUM_EN
          ck_phase_d = 1'b1;
          state_d    = ST_RECV;
`else
          state_d    = ST_FIN;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cpu_stall_d = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      word_total_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_stall_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      ck_phase_q   <= 1'b0;
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      word_total_q <= word_total_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_stall_q  <= cpu_stall_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      ck_phase_q   <= ck_phase_d;
      csum_q       <= csum_d;
`endif
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_stall = cpu_stall_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_stall;
  logic        done;
  logic        error;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] words [$];
  logic [31:0] last_wr_data;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_stall"}, cpu_stall, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Expectations come from byte counts: a data word completes on every 4th accepted byte,
  // its write shows one cycle later, and Done follows the last write (or the checksum word).
  task automatic run_load(input logic [7:0] wc, input int gap_pct, input bit gap3,
                          input bit start_noise, input logic [31:0] ck_delta, input int abort_at);
    logic [7:0]  bytes [$];
    logic [31:0] x, w;
    int          total_b, n_acc, comp_age, gap_left, done_cnt;
    bit          over, immediate, exp_wr, exp_done, exp_ready, final_err, acc, gap_used;
    over = (wc > 8'd128);
    x = '0;
    if (!over) begin
      for (int i = 0; i < int'(wc); i++) begin
        w = words[i];
        x ^= w;
        for (int b = 3; b >= 0; b--) bytes.push_back(w[8*b +: 8]);
      end
      if (CK) begin
        x ^= ck_delta;
        for (int b = 3; b >= 0; b--) bytes.push_back(x[8*b +: 8]);
      end
    end
    total_b   = bytes.size();
    immediate = over || (!CK && wc == 8'd0);
    final_err = over || (CK && ck_delta != 0);

    start = 1'b1; word_count = wc; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_acc = 0; comp_age = 100; gap_left = 0; gap_used = 0; done_cnt = 0; exp_done = 0;
    for (int k = 1; k < 5000; k++) begin
      exp_wr    = !immediate && comp_age == 1 && n_acc > 0 && n_acc % 4 == 0 && n_acc <= 4 * int'(wc);
      exp_done  = immediate ? (k == 1) : (n_acc == total_b && comp_age == (CK ? 1 : 2));
      exp_ready = !immediate && n_acc < total_b && !exp_wr;
      chk("cpu_stall", cpu_stall, 1);
      chk("done", done, exp_done);
      chk("byte_ready", byte_ready, exp_ready);
      chk("wr_en", wr_en, exp_wr);
      chk("error", error, exp_done ? final_err : 1'b0);
      if (exp_wr) begin
        chk("wr_addr", wr_addr, n_acc / 4 - 1);
        chk("wr_data", wr_data, words[n_acc/4-1]);
        last_wr_data = words[n_acc/4-1];
      end else begin
        chk("wr_data_hold", wr_data, last_wr_data);
      end
      done_cnt += int'(done);
      if (exp_done) break;
      if (abort_at >= 0 && n_acc == abort_at) return;
      if (gap3 && !gap_used && n_acc == 2) begin gap_left = 3; gap_used = 1; end
      byte_valid = (gap_left == 0) && ($urandom_range(99) >= gap_pct);
      byte_in    = (n_acc < total_b) ? bytes[n_acc] : 8'($urandom);
      if (gap_left > 0) gap_left--;
      start      = start_noise && ($urandom_range(3) == 0);
      word_count = $urandom_range(1) ? 8'd0 : 8'd200;
      acc = byte_valid && exp_ready;
      if (acc) n_acc++;
      comp_age = (acc && n_acc % 4 == 0) ? 1 : comp_age + 1;
      @(negedge clk);
    end
    chk("done_reached", exp_done, 1);
    chk("done_pulses", done_cnt, 1);
    start = 1'b0; byte_valid = 1'b0; word_count = 8'd0;
    @(negedge clk);
    chk("idle_stall", cpu_stall, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", byte_ready, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_error", error, final_err);
    chk("idle_wr_data", wr_data, last_wr_data);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; word_count = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
    last_wr_data = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    words = '{32'h2008_0005, 32'h8C09_0004};
    run_load(8'd2, 0, 1'b0, 1'b0, 32'h0, -1);
    run_load(8'd2, 0, 1'b1, 1'b0, 32'h0, -1);

    run_load(8'd200, 0, 1'b0, 1'b0, 32'h0, -1);
    fill_words(1);
    run_load(8'd1, 20, 1'b0, 1'b0, 32'h0, -1);

    run_load(8'd0, 0, 1'b0, 1'b0, 32'h0, -1);
    fill_words(3);
    run_load(8'd3, 30, 1'b0, 1'b1, 32'h0, -1);

    for (int r = 0; r < 6; r++) begin
      fill_words(1 + int'($urandom_range(5)));
      run_load(8'(words.size()), 35, 1'b0, 1'b1, 32'h0, -1);
    end

    fill_words(128);
    run_load(8'd128, 0, 1'b0, 1'b0, 32'h0, -1);
    run_load(8'd129, 0, 1'b0, 1'b0, 32'h0, -1);

    fill_words(2);
    run_load(8'd2, 10, 1'b0, 1'b0, 32'h0, 6);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    last_wr_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words = '{32'hA1B2_C3D4};
    run_load(8'd1, 25, 1'b0, 1'b0, 32'h0, -1);

`ifdef LOADER_CHECKSUM_EN
    words = '{32'h1111_1111, 32'h2222_2222};
    run_load(8'd2, 0, 1'b0, 1'b0, 32'h0, -1);
    run_load(8'd2, 0, 1'b0, 1'b0, 32'h0000_0007, -1);
    run_load(8'd0, 0, 1'b0, 1'b0, 32'h0000_0100, -1);
    fill_words(4);
    run_load(8'd4, 30, 1'b0, 1'b1, 32'h8000_0000, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
